// File: rtl/fsk_symbol_scheduler_if.sv
// rtl/fsk_symbol_scheduler_if.sv - host word stream and DDS control bundle for the FSK symbol scheduler
//
// Purpose: groups the code-word handshake, the mark/space tuning words, the
// DDS phase-zero pulse and the scheduler outputs into one bundle.
//   master : host / DDS side (drives words, tuning words, phase_zero)
//   slave  : fsk_symbol_scheduler (drives word_ready and all DDS/status outputs)
// Signals:
//   word_data[15:0], word_valid, word_ready : code-word push handshake
//   mark_ftw, space_ftw                     : tuning words for bit 1 / bit 0
//   phase_zero                              : DDS accumulator zero-crossing pulse
//   dds_ftw, dds_ftw_load                   : tuning word to DDS and its load pulse
//   sym_bit, sym_strobe                     : bit on air and start-of-symbol pulse
//   busy, burst_done                        : scheduler activity and end-of-burst pulse

interface fsk_symbol_scheduler_if #(
    parameter int FTW_W = 32
) ();
    logic [15:0]      word_data;
    logic             word_valid;
    logic             word_ready;
    logic [FTW_W-1:0] mark_ftw;
    logic [FTW_W-1:0] space_ftw;
    logic             phase_zero;
    logic [FTW_W-1:0] dds_ftw;
    logic             dds_ftw_load;
    logic             sym_bit;
    logic             sym_strobe;
    logic             busy;
    logic             burst_done;

    modport master (
        output word_data, word_valid, mark_ftw, space_ftw, phase_zero,
        input  word_ready, dds_ftw, dds_ftw_load, sym_bit, sym_strobe, busy, burst_done
    );

    modport slave (
        input  word_data, word_valid, mark_ftw, space_ftw, phase_zero,
        output word_ready, dds_ftw, dds_ftw_load, sym_bit, sym_strobe, busy, burst_done
    );
endinterface

// File: rtl/fsk_symbol_scheduler.sv
// rtl/fsk_symbol_scheduler.sv - FSK transmit sequencer with phase-aligned DDS tuning-word switching
//
// Purpose: buffers 16-bit code words in a small FIFO, serializes them MSB
// first at BAUD_DIV clocks per symbol and selects the DDS tuning word
// (mark for 1, space for 0). A tuning-word change waits in ALIGN for a DDS
// phase-zero pulse, or is forced after ALIGN_TIMEOUT cycles.
// Ports:
//   clk_100M : system clock
//   rst_n    : asynchronous active-low reset (flushes FIFO, aborts word)
//   bus      : fsk_symbol_scheduler_if.slave (word handshake, tuning words,
//              phase_zero in; dds_ftw/dds_ftw_load/sym_bit/sym_strobe/busy/
//              burst_done out)
// Optional feature macro: PREAMBLE_EN - when defined, every burst leaving
//   IDLE is preceded by the word 16'hAAAA, sent without popping the FIFO.

module fsk_symbol_scheduler #(
    parameter int BAUD_DIV      = 9766,
    parameter int FIFO_DEPTH    = 4,
    parameter int FTW_W         = 32,
    parameter int ALIGN_TIMEOUT = 1024
) (
    input  logic                  clk_100M,
    input  logic                  rst_n,
    fsk_symbol_scheduler_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int TW = (ALIGN_TIMEOUT > 1) ? $clog2(ALIGN_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ALIGN,
        S_HOLD
    } state_t;

    state_t           state;
    logic [15:0]      shreg;
    logic [3:0]       bit_idx;
    logic [BW-1:0]    baud_cnt;
    logic [TW-1:0]    align_cnt;
    logic [FTW_W-1:0] tgt;
    logic             tgt_bit;

    // FIFO storage and pointers
    logic [15:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             hold_end;
    logic             nxt_bit;
    logic [FTW_W-1:0] nxt_tgt;

    assign fifo_empty     = (count == '0);
    assign bus.word_ready = (count != (AW+1)'(FIFO_DEPTH));
    assign push           = bus.word_valid && bus.word_ready;
    assign hold_end       = (state == S_HOLD) && (baud_cnt == BW'(BAUD_DIV - 1));

    // The FIFO is popped only at a word boundary; with the preamble enabled
    // IDLE loads the constant instead, and the first real word is popped
    // when the preamble's last bit ends.
`ifdef PREAMBLE_EN
    assign pop = hold_end && (bit_idx == 4'd0) && !fifo_empty;
`else
    assign pop = ((state == S_IDLE) || (hold_end && (bit_idx == 4'd0))) && !fifo_empty;
`endif

    assign nxt_bit = shreg[bit_idx];
    assign nxt_tgt = nxt_bit ? bus.mark_ftw : bus.space_ftw;

    always_ff @(posedge clk_100M) begin
        if (push) begin
            mem[wr_ptr] <= bus.word_data;
        end
    end

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_100M or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            shreg            <= '0;
            bit_idx          <= '0;
            baud_cnt         <= '0;
            align_cnt        <= '0;
            tgt              <= '0;
            tgt_bit          <= 1'b0;
            bus.dds_ftw      <= '0;
            bus.dds_ftw_load <= 1'b0;
            bus.sym_bit      <= 1'b0;
            bus.sym_strobe   <= 1'b0;
            bus.busy         <= 1'b0;
            bus.burst_done   <= 1'b0;
        end else begin
            bus.dds_ftw_load <= 1'b0;
            bus.sym_strobe   <= 1'b0;
            bus.burst_done   <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
`ifdef PREAMBLE_EN
                        shreg <= 16'hAAAA;
`else
                        shreg <= mem[rd_ptr];
`endif
                        bit_idx  <= 4'd15;
                        bus.busy <= 1'b1;
                        state    <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    // Latch the target so tuning-word changes on the inputs
                    // cannot disturb a pending switch.
                    tgt     <= nxt_tgt;
                    tgt_bit <= nxt_bit;
                    if (nxt_tgt == bus.dds_ftw) begin
                        bus.sym_strobe <= 1'b1;
                        bus.sym_bit    <= nxt_bit;
                        baud_cnt       <= '0;
                        state          <= S_HOLD;
                    end else begin
                        align_cnt <= '0;
                        state     <= S_ALIGN;
                    end
                end

                S_ALIGN: begin
                    if (bus.phase_zero || (align_cnt == TW'(ALIGN_TIMEOUT - 1))) begin
                        bus.dds_ftw      <= tgt;
                        bus.dds_ftw_load <= 1'b1;
                        bus.sym_strobe   <= 1'b1;
                        bus.sym_bit      <= tgt_bit;
                        baud_cnt         <= '0;
                        state            <= S_HOLD;
                    end else begin
                        align_cnt <= align_cnt + 1'b1;
                    end
                end

                S_HOLD: begin
                    if (hold_end) begin
                        if (bit_idx != 4'd0) begin
                            bit_idx <= bit_idx - 1'b1;
                            state   <= S_LOAD;
                        end else if (!fifo_empty) begin
                            shreg   <= mem[rd_ptr];
                            bit_idx <= 4'd15;
                            state   <= S_LOAD;
                        end else begin
                            bus.burst_done <= 1'b1;
                            bus.busy       <= 1'b0;
                            state          <= S_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fsk_symbol_scheduler.sv
// tb/tb_fsk_symbol_scheduler.sv - self-checking bench for fsk_symbol_scheduler

module tb_fsk_symbol_scheduler;
    localparam int BAUD  = 8;
    localparam int TO    = 16;
    localparam int DEPTH = 4;
`ifdef PREAMBLE_EN
    localparam bit PRE = 1'b1;
`else
    localparam bit PRE = 1'b0;
`endif

    logic clk_100M = 1'b0;
    logic rst_n    = 1'b0;

    always #5 clk_100M = ~clk_100M;

    fsk_symbol_scheduler_if #(.FTW_W(32)) bus ();

    fsk_symbol_scheduler #(
        .BAUD_DIV     (BAUD),
        .FIFO_DEPTH   (DEPTH),
        .FTW_W        (32),
        .ALIGN_TIMEOUT(TO)
    ) dut (
        .clk_100M(clk_100M),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor: append-only event log sampled on the falling edge
    int   cyc = 0;
    bit   obs_bits[$];
    int   strobe_cyc[$];
    int   load_cyc[$];
    int   busy_rise_cyc[$];
    int   burst_cnt     = 0;
    int   busy_fall_cnt = 0;
    logic prev_busy     = 1'b0;

    always @(negedge clk_100M) begin
        cyc = cyc + 1;
        if (bus.sym_strobe) begin
            obs_bits.push_back(bus.sym_bit);
            strobe_cyc.push_back(cyc);
        end
        if (bus.dds_ftw_load) load_cyc.push_back(cyc);
        if (bus.burst_done) burst_cnt = burst_cnt + 1;
        if (bus.busy && !prev_busy) busy_rise_cyc.push_back(cyc);
        if (!bus.busy && prev_busy) busy_fall_cnt = busy_fall_cnt + 1;
        prev_busy = bus.busy;
    end

    typedef struct {
        logic [15:0] word;
        logic [31:0] mark;
        logic [31:0] space;
        bit          pz;
        int          loads_np;
        int          loads_pre;
        logic [31:0] final_ftw;
        bit          last_bit;
        int          first_load;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_100M);
        #1;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_flags"},
              {60'd0, bus.dds_ftw_load, bus.sym_bit, bus.sym_strobe, bus.busy},
              64'd0);
        check({name, "_burst_ready"}, {62'd0, bus.burst_done, bus.word_ready}, 64'd1);
        check({name, "_ftw"}, {32'd0, bus.dds_ftw}, 64'd0);
    endtask

    task automatic do_reset();
        tick();
        bus.word_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset");
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic push_word(input logic [15:0] w);
        int t;
        t = 0;
        bus.word_data  = w;
        bus.word_valid = 1'b1;
        while (!bus.word_ready && t < 500) begin
            tick();
            t++;
        end
        if (t >= 500) check("push_timeout", 64'd1, 64'd0);
        tick();
        bus.word_valid = 1'b0;
    endtask

    task automatic wait_burst(input int b0);
        int t;
        t = 0;
        while (burst_cnt == b0 && t < 6000) begin
            tick();
            t++;
        end
        check("burst_wait", {63'd0, burst_cnt != b0}, 64'd1);
    endtask

    task automatic push_bits(inout bit q[$], input logic [15:0] w);
        for (int k = 15; k >= 0; k--) q.push_back(w[k]);
    endtask

    task automatic compare_bits(input string name, input int s0, input bit exp[$]);
        int bad;
        bad = 0;
        check({name, "_count"}, 64'(obs_bits.size() - s0), 64'(exp.size()));
        for (int k = 0; k < exp.size(); k++) begin
            if (s0 + k >= obs_bits.size()) bad++;
            else if (obs_bits[s0 + k] != exp[k]) bad++;
        end
        check({name, "_seq"}, 64'(bad), 64'd0);
    endtask

    task automatic check_intervals(input string name, input int s0, input int alt);
        int bad;
        int d;
        bad = 0;
        for (int k = s0 + 1; k < strobe_cyc.size(); k++) begin
            d = strobe_cyc[k] - strobe_cyc[k-1];
            if (!((d == BAUD + 1) || (d == alt))) bad++;
        end
        check({name, "_intervals"}, 64'(bad), 64'd0);
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        bit   exp[$];
        int   s0, l0, b0, fl;
        v = vecs[i];
        do_reset();
        bus.mark_ftw   = v.mark;
        bus.space_ftw  = v.space;
        bus.phase_zero = v.pz;
        s0 = obs_bits.size();
        l0 = load_cyc.size();
        b0 = burst_cnt;
        push_word(v.word);
        wait_burst(b0);
        repeat (3) tick();
        if (PRE) push_bits(exp, 16'hAAAA);
        push_bits(exp, v.word);
        compare_bits($sformatf("v%0d_bits", i), s0, exp);
        check($sformatf("v%0d_loads", i), 64'(load_cyc.size() - l0),
              64'(PRE ? v.loads_pre : v.loads_np));
        check($sformatf("v%0d_burst_done", i), 64'(burst_cnt - b0), 64'd1);
        check($sformatf("v%0d_final_ftw", i), {32'd0, bus.dds_ftw}, {32'd0, v.final_ftw});
        check($sformatf("v%0d_idle", i), {62'd0, bus.busy, bus.sym_bit}, {62'd0, 1'b0, v.last_bit});
        fl = -1;
        if (load_cyc.size() > l0 && busy_rise_cyc.size() > 0)
            fl = load_cyc[l0] - busy_rise_cyc[busy_rise_cyc.size() - 1];
        check($sformatf("v%0d_first_switch", i), 64'(fl), 64'(v.first_load));
        check_intervals($sformatf("v%0d", i), s0, v.pz ? BAUD + 2 : BAUD + 1 + TO);
    endtask

    initial begin
        logic [15:0] words[5];
        bit   exp[$];
        int   s0, b0, f0, acc, t, first_low;

        bus.word_data  = '0;
        bus.word_valid = 1'b0;
        bus.mark_ftw   = '0;
        bus.space_ftw  = '0;
        bus.phase_zero = 1'b0;

        //          word      mark          space         pz  np  pre  final         last fl
        vecs[0] = '{16'hA5A5, 32'h0000_0100, 32'h0000_0080, 1, 13, 29, 32'h0000_0100, 1, 2};
        vecs[1] = '{16'hFFFF, 32'h0000_0100, 32'h0000_0100, 1,  1,  1, 32'h0000_0100, 1, 2};
        vecs[2] = '{16'h0000, 32'h0000_0100, 32'h0000_0080, 0,  1, 16, 32'h0000_0080, 0, 17};
        vecs[3] = '{16'h1234, 32'h0000_1111, 32'h0000_2222, 1,  9, 24, 32'h0000_2222, 0, 2};
        vecs[4] = '{16'h8000, 32'h0000_0100, 32'h0000_0080, 0,  2, 18, 32'h0000_0080, 0, 17};

        #1;
        check_reset_outputs("por");

        for (int i = 0; i < 5; i++) run_vec(i);

        // Back-to-back burst with word_valid held high
        do_reset();
        bus.mark_ftw   = 32'h0000_0100;
        bus.space_ftw  = 32'h0000_0080;
        bus.phase_zero = 1'b1;
        words[0] = 16'hC3A1;
        words[1] = 16'h0F0F;
        words[2] = 16'h7E81;
        words[3] = 16'h5555;
        words[4] = 16'h9234;
        s0 = obs_bits.size();
        b0 = burst_cnt;
        f0 = busy_fall_cnt;
        acc = 0;
        t = 0;
        first_low = -1;
        bus.word_data  = words[0];
        bus.word_valid = 1'b1;
        while (acc < 5 && t < 1000) begin
            if (bus.word_ready) begin
                tick();
                acc++;
                if (acc < 5) bus.word_data = words[acc];
            end else begin
                if (first_low < 0) first_low = acc;
                tick();
            end
            t++;
        end
        bus.word_valid = 1'b0;
        if (first_low < 0 && !bus.word_ready) first_low = acc;
        check("b2b_accepted", 64'(acc), 64'd5);
        check("b2b_full_after_last", {63'd0, bus.word_ready}, 64'd0);
        check("b2b_ready_drop_at", 64'(first_low), 64'(PRE ? 4 : 5));
        wait_burst(b0);
        repeat (3) tick();
        if (PRE) push_bits(exp, 16'hAAAA);
        for (int k = 0; k < 5; k++) push_bits(exp, words[k]);
        compare_bits("b2b_bits", s0, exp);
        check("b2b_burst_done", 64'(burst_cnt - b0), 64'd1);
        check("b2b_busy_falls", 64'(busy_fall_cnt - f0), 64'd1);
        check_intervals("b2b", s0, BAUD + 2);

        // Reset in the middle of a word with two words still queued
        do_reset();
        acc = 0;
        t = 0;
        s0 = obs_bits.size();
        bus.word_data  = 16'h6C3E;
        bus.word_valid = 1'b1;
        while (acc < 3 && t < 1000) begin
            if (bus.word_ready) begin
                tick();
                acc++;
                bus.word_data = bus.word_data + 16'h1111;
            end else begin
                tick();
            end
            t++;
        end
        bus.word_valid = 1'b0;
        t = 0;
        while (obs_bits.size() - s0 < 9 && t < 2000) begin
            tick();
            t++;
        end
        check("mid_reached_bit7", {63'd0, (obs_bits.size() - s0) >= 9}, 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        repeat (2) tick();
        rst_n = 1'b1;
        s0 = obs_bits.size();
        b0 = burst_cnt;
        repeat (300) tick();
        check("mid_no_strobes", 64'(obs_bits.size() - s0), 64'd0);
        check("mid_no_burst", 64'(burst_cnt - b0), 64'd0);
        check("mid_idle", {62'd0, bus.busy, bus.word_ready}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fsk_symbol_scheduler.md
Name: fsk_symbol_scheduler

Overview:
Sequences the FSK transmit path. It buffers 16-bit code words from a host, serializes them MSB-first at a fixed baud, and drives the DDS tuning word: mark for bit 1, space for bit 0. Frequency changes are held until the DDS reports a phase-zero crossing, which keeps the switch phase-continuous. A timeout forces the change if no crossing arrives.

Parameters:
BAUD_DIV, 9766, clk_100M cycles per symbol hold (about 10.24 kBd)
FIFO_DEPTH, 4, code-word buffer depth; power of 2, at least 2
FTW_W, 32, DDS frequency tuning word width
ALIGN_TIMEOUT, 1024, maximum cycles to wait for phase_zero before forcing the switch

Ports:
clk_100M  in  1  system clock
rst_n  in  1  asynchronous active-low reset
word_data  in  16  code word to transmit, MSB first
word_valid  in  1  word_data valid
word_ready  out  1  FIFO can accept a word
mark_ftw  in  FTW_W  tuning word for bit 1
space_ftw  in  FTW_W  tuning word for bit 0
phase_zero  in  1  DDS phase-accumulator zero-crossing pulse
dds_ftw  out  FTW_W  tuning word to DDS
dds_ftw_load  out  1  1-cycle pulse when dds_ftw changes
sym_bit  out  1  bit currently on air
sym_strobe  out  1  1-cycle pulse at start of each symbol
busy  out  1  state not IDLE
burst_done  out  1  1-cycle pulse when the last bit of the last buffered word ends

Behaviour:
- One clock domain. rst_n is asynchronous and active-low. Everything else is synchronous to clk_100M.
- Reset values: dds_ftw=0, dds_ftw_load=0, sym_bit=0, sym_strobe=0, busy=0, burst_done=0. FIFO is empty, so word_ready=1. FSM is in IDLE.
- FIFO:
  - Push when word_valid && word_ready. word_ready = (count != FIFO_DEPTH), decoded combinationally from registered count.
  - Pop happens only inside the FSM. Simultaneous push and pop leave count unchanged.
  - A push into an empty FIFO is visible to the FSM on the next cycle.
- FSM states: IDLE, LOAD, ALIGN, HOLD.
  - IDLE: if FIFO is non-empty, pop the word into the shift register, set bit_idx=15, go to LOAD.
  - LOAD (exactly 1 cycle):
    - Sample the next bit b=shreg[bit_idx] and tgt = b ? mark_ftw : space_ftw.
    - If tgt == dds_ftw: assert sym_strobe, set sym_bit=b, clear baud_cnt, go to HOLD. No dds_ftw_load is issued.
    - Otherwise go to ALIGN and clear align_cnt.
  - ALIGN:
    - Each cycle, if phase_zero==1 or align_cnt==ALIGN_TIMEOUT-1: set dds_ftw=tgt, pulse dds_ftw_load and sym_strobe, set sym_bit=b, clear baud_cnt, go to HOLD.
    - Otherwise increment align_cnt.
    - tgt is latched in LOAD. Changes to mark_ftw/space_ftw during ALIGN or HOLD have no effect until the next LOAD.
  - HOLD:
    - baud_cnt counts 0..BAUD_DIV-1. At BAUD_DIV-1 the next action depends on bit_idx and the FIFO:
    - bit_idx>0: decrement bit_idx, go to LOAD.
    - bit_idx==0 and FIFO non-empty: pop, set bit_idx=15, go to LOAD. There is no gap beyond the LOAD cycle.
    - bit_idx==0 and FIFO empty: pulse burst_done, go to IDLE.
- Timing:
  - On-air symbol length = BAUD_DIV cycles in HOLD + 1 LOAD cycle + ALIGN wait, where the ALIGN wait is 0..ALIGN_TIMEOUT cycles.
  - Worst case: BAUD_DIV+1+ALIGN_TIMEOUT.
- IDLE holds dds_ftw and sym_bit at their last values. The carrier is not forced.
- Reset mid-operation flushes the FIFO and shift register and returns to reset values immediately. A partially sent word is lost.
- phase_zero outside ALIGN is ignored.

Optional Feature:
PREAMBLE_EN
- Defined: leaving IDLE first loads the constant 16'hAAAA into the shift register without popping the FIFO. The preamble is sent as a normal word. When it ends, the FIFO word is popped. Seamless back-to-back words inside a burst get no preamble; every burst after an IDLE gets one. busy covers the preamble.
- Undefined: the first FIFO word is sent directly.

Test Plan:
- BAUD_DIV=8, mark=32'h0100, space=32'h0080, phase_zero tied 1, push 16'hA5A5 -> sym_bit sequence 1,0,1,0,0,1,0,1,1,0,1,0,0,1,0,1; each symbol is 9 or 10 cycles; dds_ftw_load only on bit changes; then burst_done pulse and IDLE.
- phase_zero held 0, ALIGN_TIMEOUT=16, push 16'h8000 -> first switch exactly 16 cycles after LOAD; dds_ftw=32'h0100.
- Push 5 words with word_valid held high, FIFO_DEPTH=4 -> word_ready drops after the 4th accepted word (the 1st may already be popped; check by count); all 5 words are sent back-to-back with no IDLE between; one burst_done.
- Push 16'hFFFF with mark==space==32'h0100 -> no dds_ftw_load after the first symbol; 16 sym_strobe pulses.
- Assert rst_n=0 at bit 7 of a word with 2 words queued -> all outputs return to reset values, word_ready=1, no further strobes.
- PREAMBLE_EN defined, push 16'h0000 -> 16'hAAAA bits then 16 zeros, with one burst_done at the end.
